// File: rtl/mac_driver_pkg.sv
// mac_driver_pkg: shared types and constants for the mac atom driver
package mac_driver_pkg;
  localparam int DEF_COUNT_WIDTH = 32;
  localparam int DEF_SEQ_WIDTH = 8;
  localparam int NOP_CONSTANT = 1;
  localparam int SEL1_IDX = 0;
  localparam int SEL2_IDX = 1;
  localparam int SEL3_IDX = 2;
  typedef struct packed {
    logic [DEF_COUNT_WIDTH-1:0] pkt_1;
    logic [DEF_COUNT_WIDTH-1:0] pkt_2;
    logic [DEF_COUNT_WIDTH-1:0] pkt_3;
  } pkt_t;
  typedef struct packed {
    logic [DEF_COUNT_WIDTH-1:0] read;
    logic [DEF_COUNT_WIDTH-1:0] write;
    logic [DEF_SEQ_WIDTH-1:0] tag;
  } result_t;
  typedef enum logic {INIT, RUN} state_e;
endpackage

// File: rtl/mac_driver_if.sv
// mac_driver_if: packet input and tagged result output streams of the mac driver
interface mac_driver_if #(parameter int W = 32, parameter int SW = 8);
  logic in_valid;
  logic in_ready;
  logic [W-1:0] in_pkt_1;
  logic [W-1:0] in_pkt_2;
  logic [W-1:0] in_pkt_3;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out_read;
  logic [W-1:0] out_write;
  logic [SW-1:0] out_tag;
  modport master (
    output in_valid, in_pkt_1, in_pkt_2, in_pkt_3, out_ready,
    input in_ready, out_valid, out_read, out_write, out_tag
  );
  modport slave (
    input in_valid, in_pkt_1, in_pkt_2, in_pkt_3, out_ready,
    output in_ready, out_valid, out_read, out_write, out_tag
  );
endinterface

// File: rtl/mac_sync_fifo.sv
// mac_sync_fifo: synchronous FIFO with occupancy count, full and empty flags
module mac_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  // storage needs no reset: occupancy decides whether the head is meaningful
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wp] <= i_data;
  // pointers and occupancy; callers never push when full nor pop when empty
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= nxt(r_wp);
      if (i_pop) r_rp <= nxt(r_rp);
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  assign o_data = r_mem[r_rp];
  assign o_count = r_cnt;
  assign o_full = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
endmodule

// File: rtl/mac_driver.sv
// mac_driver: issues queued packets to the mac atom, owns its init, returns tagged results
module mac_driver import mac_driver_pkg::*; #(
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int IN_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int SEQ_WIDTH = DEF_SEQ_WIDTH,
  parameter logic [COUNT_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mac_driver_if.slave            bus,
  input  logic [COUNT_WIDTH-1:0] i__cfg_constant,
  input  logic [2:0]             i__cfg_sel,
  input  logic                   i__init_req,
  input  logic [COUNT_WIDTH-1:0] i__init_value,
  output logic [COUNT_WIDTH-1:0] o__atom_constant,
  output logic [COUNT_WIDTH-1:0] o__atom_pkt_1,
  output logic [COUNT_WIDTH-1:0] o__atom_pkt_2,
  output logic [COUNT_WIDTH-1:0] o__atom_pkt_3,
  output logic                   o__atom_sel1,
  output logic                   o__atom_sel2,
  output logic                   o__atom_sel3,
  input  logic [COUNT_WIDTH-1:0] i__atom_read,
  input  logic [COUNT_WIDTH-1:0] i__atom_write
);
  localparam int W = COUNT_WIDTH;
  localparam int RW = 2 * W + SEQ_WIDTH;
  localparam int ICW = $clog2(IN_DEPTH + 1);
  localparam int RCW = $clog2(RES_DEPTH + 1);
  state_e r_state;
  logic r_init_pend, r_fly_vld, r_fly_rep;
  logic [W-1:0] r_init_val;
  logic [SEQ_WIDTH-1:0] r_tag;
  logic [3*W-1:0] w_in_data;
  logic [RW-1:0] w_res_data;
  logic [ICW-1:0] w_in_cnt;
  logic [RCW-1:0] w_res_cnt;
  logic w_in_full, w_in_empty, w_res_full, w_res_empty;
  logic w_in_push, w_res_push, w_res_pop, w_res_room;
  logic w_issue_init, w_issue_pkt, w_unused;
  logic [W-1:0] w_init_v;
  mac_sync_fifo #(.WIDTH(3 * W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk(clk), .rst_n(rst_n), .i_push(w_in_push),
    .i_data({bus.in_pkt_1, bus.in_pkt_2, bus.in_pkt_3}), .i_pop(w_issue_pkt),
    .o_data(w_in_data), .o_count(w_in_cnt), .o_full(w_in_full), .o_empty(w_in_empty)
  );
  mac_sync_fifo #(.WIDTH(RW), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk(clk), .rst_n(rst_n), .i_push(w_res_push),
    .i_data({i__atom_read, i__atom_write, r_tag}), .i_pop(w_res_pop),
    .o_data(w_res_data), .o_count(w_res_cnt), .o_full(w_res_full), .o_empty(w_res_empty)
  );
  assign w_unused = ^{w_in_cnt, w_res_full};
  assign bus.in_ready = rst_n & (r_state == RUN) & ~w_in_full;
  assign w_in_push = bus.in_valid & bus.in_ready;
  assign bus.out_valid = ~w_res_empty;
  assign w_res_pop = ~w_res_empty & bus.out_ready;
  assign {bus.out_read, bus.out_write, bus.out_tag} = w_res_data;
  assign w_res_push = r_fly_vld & r_fly_rep;
  assign w_res_room = r_fly_rep ? (w_res_cnt < RCW'(RES_DEPTH - 1)) : (w_res_cnt < RCW'(RES_DEPTH));
  assign w_issue_init = rst_n & ((r_state == INIT) | r_init_pend);
  assign w_issue_pkt = rst_n & (r_state == RUN) & ~r_init_pend & ~w_in_empty & w_res_room;
  assign w_init_v = r_state == INIT ? INIT_VALUE : r_init_val;
  // issue mux: packet, init write or NOP that holds the atom register
  always_comb begin
    o__atom_constant = w_issue_pkt ? i__cfg_constant : w_issue_init ? '0 : W'(NOP_CONSTANT);
    o__atom_pkt_1 = w_issue_pkt ? w_in_data[3*W-1:2*W] : '0;
    o__atom_pkt_2 = w_issue_pkt ? w_in_data[2*W-1:W] : w_issue_init ? w_init_v : '0;
    o__atom_pkt_3 = w_issue_pkt ? w_in_data[W-1:0] : '0;
    o__atom_sel1 = w_issue_pkt ? i__cfg_sel[SEL1_IDX] : w_issue_init;
    o__atom_sel2 = w_issue_pkt & i__cfg_sel[SEL2_IDX];
    o__atom_sel3 = w_issue_pkt & i__cfg_sel[SEL3_IDX];
  end
  // FSM, pending re-init, one-stage in-flight flag and result tag counter
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= INIT;
      r_init_pend <= 1'b0;
      r_init_val <= '0;
      r_fly_vld <= 1'b0;
      r_fly_rep <= 1'b0;
      r_tag <= '0;
    end else begin
      r_state <= RUN;
      r_init_pend <= i__init_req | (r_init_pend & (r_state == INIT));
      if (i__init_req) r_init_val <= i__init_value;
      r_fly_vld <= w_issue_init | w_issue_pkt;
      r_fly_rep <= w_issue_pkt;
      if (w_res_push) r_tag <= r_tag + SEQ_WIDTH'(1);
    end
endmodule
